alu_share_seq: RTL and testbench

- Shares one external 8-bit combinational ALU between two requesters and executes 16-bit operations as chained byte passes.
- Each pass forwards the previous pass's carry-out as the next pass's carry-in.
- Arbitration is round-robin. Requests use a valid/ready handshake; responses use valid/ready with requester ID.
- Sits between client blocks and the ALU; it owns all ALU input drive.

---
 rtl/alu_share_seq_pkg.sv | 18 +
 rtl/alu_share_seq_if.sv | 57 +++++
 rtl/alu_share_seq_rr_arb2.sv | 32 +++
 rtl/alu_share_seq.sv | 116 +++++++++++
 tb/tb_alu_share_seq.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_seq_pkg.sv
// Shared types and constants for the byte-sliced shared ALU sequencer.
package alu_share_seq_pkg;

    localparam int OPER_W    = 3;
    localparam int DW_DEF    = 8;
    localparam int NPASS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_share_seq_if.sv
// Requester, ALU and response bundle of the shared ALU sequencer.
interface alu_share_seq_if #(
    parameter int DW    = 8,
    parameter int NPASS = 2
);
    localparam int W = DW * NPASS;

    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_oper;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_cin;

    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_oper;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_cin;

    logic [2:0]    alu_oper;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_cin;
    logic [DW-1:0] alu_sum;
    logic          alu_cout;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;

    modport slave (
        input  req0_valid, req0_oper, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_oper, req1_a, req1_b, req1_cin,
        output req1_ready,
        output alu_oper, alu_a, alu_b, alu_cin,
        input  alu_sum, alu_cout,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_oper, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_oper, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  alu_oper, alu_a, alu_b, alu_cin,
        output alu_sum, alu_cout,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout,
        output rsp_ready
    );

endinterface

// File: rtl/alu_share_seq_rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       last_nxt
);

    always_comb begin
        gnt      = 2'b00;
        last_nxt = last;
        if (en) begin
            unique case (1'b1)
                (valid == 2'b11): begin
                    gnt      = last ? 2'b01 : 2'b10;
                    last_nxt = ~last;
                end
                (valid == 2'b01): begin
                    gnt      = 2'b01;
                    last_nxt = 1'b0;
                end
                (valid == 2'b10): begin
                    gnt      = 2'b10;
                    last_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_share_seq.sv
// Shares one DW-bit ALU between two requesters, running W-bit ops as chained passes.
module alu_share_seq
    import alu_share_seq_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int NPASS = NPASS_DEF
) (
    input logic            clk,
    input logic            rst,
    alu_share_seq_if.slave bus
);

    localparam int W  = DW * NPASS;
    localparam int KW = cnt_w(NPASS);
    localparam logic [KW-1:0] K_LAST = KW'(NPASS - 1);

    state_t              state;
    logic                last_grant;
    logic                last_nxt;
    logic [1:0]          gnt;
    logic                arb_en;
    logic [OPER_W-1:0]   oper_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        res_q;
    logic [W-1:0]        res_nxt;
    logic                cin_q;
    logic                carry_q;
    logic                id_q;
    logic [KW-1:0]       k;

    // Ready is combinational but must stay low while reset is held.
    assign arb_en = (state == IDLE) && !rst;

    rr_arb2 u_arb (
        .valid    ({bus.req1_valid, bus.req0_valid}),
        .en       (arb_en),
        .last     (last_grant),
        .gnt      (gnt),
        .last_nxt (last_nxt)
    );

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    always_comb begin
        bus.alu_oper = '0;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.alu_cin  = 1'b0;
        res_nxt      = res_q;
        if (state == EXEC) begin
            bus.alu_oper = oper_q;
            bus.alu_a    = a_q[k*DW +: DW];
            bus.alu_b    = b_q[k*DW +: DW];
            bus.alu_cin  = (k == '0) ? cin_q : carry_q;
            res_nxt[k*DW +: DW] = bus.alu_sum;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            oper_q        <= '0;
            a_q           <= '0;
            b_q           <= '0;
            res_q         <= '0;
            cin_q         <= 1'b0;
            carry_q       <= 1'b0;
            id_q          <= 1'b0;
            k             <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_sum   <= '0;
            bus.rsp_cout  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|gnt) begin
                        oper_q     <= gnt[1] ? bus.req1_oper : bus.req0_oper;
                        a_q        <= gnt[1] ? bus.req1_a    : bus.req0_a;
                        b_q        <= gnt[1] ? bus.req1_b    : bus.req0_b;
                        cin_q      <= gnt[1] ? bus.req1_cin  : bus.req0_cin;
                        id_q       <= gnt[1];
                        last_grant <= last_nxt;
                        k          <= '0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= res_nxt;
                    carry_q <= bus.alu_cout;
                    if (k == K_LAST) begin
                        k             <= '0;
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_sum   <= res_nxt;
                        bus.rsp_cout  <= bus.alu_cout;
                        bus.rsp_id    <= id_q;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_seq.sv
// Scoreboard bench for alu_share_seq with an adder stub standing in for the ALU.
module tb_alu_share_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_seq_if #(.DW(8), .NPASS(2)) bus ();

    alu_share_seq #(.DW(8), .NPASS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign {bus.alu_cout, bus.alu_sum} =
        {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {8'd0, bus.alu_cin};

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        cout;
    } rsp_t;

    rsp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic push_exp(input logic id, input logic [15:0] sum,
                            input logic cout);
        rsp_t e;
        e.id   = id;
        e.sum  = sum;
        e.cout = cout;
        exp_q.push_back(e);
    endtask

    // Monitor: ALU pass checks, handshake rules and scoreboard pops.
    logic [2:0]  m_oper;
    logic [15:0] m_a, m_b;
    logic        m_cin, m_c0;
    int          exec_cnt = 0;
    int          acc_cyc  = 0;
    logic        p_valid  = 1'b0;
    logic        p_hs     = 1'b0;
    logic [15:0] p_sum;
    logic        p_cout, p_id;

    always @(negedge clk) begin
        if (rst) begin
            exec_cnt = 0;
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_data", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout}, 0);
            chk("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
            chk("rst_alu", {bus.alu_oper, bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
            p_valid = 1'b0;
            p_hs    = 1'b0;
        end else begin
            if (exec_cnt > 0) begin
                chk("alu_oper", bus.alu_oper, m_oper);
                if (exec_cnt == 2) begin
                    chk("pass0_a", bus.alu_a, m_a[7:0]);
                    chk("pass0_b", bus.alu_b, m_b[7:0]);
                    chk("pass0_cin", bus.alu_cin, m_cin);
                end else begin
                    chk("pass1_a", bus.alu_a, m_a[15:8]);
                    chk("pass1_b", bus.alu_b, m_b[15:8]);
                    chk("pass1_cin", bus.alu_cin, m_c0);
                end
                exec_cnt--;
            end else begin
                chk("alu_idle", {bus.alu_oper, bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
            end
            if (p_hs) chk("rsp_drop", bus.rsp_valid, 0);
            if (bus.rsp_valid) begin
                chk("busy_ready", {bus.req1_ready, bus.req0_ready}, 0);
                if (!p_valid) chk("latency", cyc - acc_cyc, 3);
                if (p_valid && !p_hs)
                    chk("rsp_stable", {bus.rsp_id, bus.rsp_sum, bus.rsp_cout},
                        {p_id, p_sum, p_cout});
                if (bus.rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_rsp: got id %0d sum %0h want none",
                                 bus.rsp_id, bus.rsp_sum);
                    end else begin
                        rsp_t e;
                        e = exp_q.pop_front();
                        chk("rsp_id", bus.rsp_id, e.id);
                        chk("rsp_sum", bus.rsp_sum, e.sum);
                        chk("rsp_cout", bus.rsp_cout, e.cout);
                    end
                end
            end
            if (bus.req0_ready || bus.req1_ready) begin
                chk("ready_onehot", int'(bus.req0_ready) + int'(bus.req1_ready), 1);
                chk("ready_valid", {bus.req1_ready & ~bus.req1_valid,
                                    bus.req0_ready & ~bus.req0_valid}, 0);
                m_oper   = bus.req1_ready ? bus.req1_oper : bus.req0_oper;
                m_a      = bus.req1_ready ? bus.req1_a    : bus.req0_a;
                m_b      = bus.req1_ready ? bus.req1_b    : bus.req0_b;
                m_cin    = bus.req1_ready ? bus.req1_cin  : bus.req0_cin;
                m_c0     = (9'(m_a[7:0]) + 9'(m_b[7:0]) + 9'(m_cin)) > 9'd255;
                exec_cnt = 2;
                acc_cyc  = cyc;
            end
            p_valid = bus.rsp_valid;
            p_hs    = bus.rsp_valid && bus.rsp_ready;
            p_sum   = bus.rsp_sum;
            p_cout  = bus.rsp_cout;
            p_id    = bus.rsp_id;
        end
    end

    task automatic set_req(input logic id, input logic [2:0] op,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic ci);
        if (id) begin
            bus.req1_oper  = op;
            bus.req1_a     = a;
            bus.req1_b     = b;
            bus.req1_cin   = ci;
            bus.req1_valid = 1'b1;
        end else begin
            bus.req0_oper  = op;
            bus.req0_a     = a;
            bus.req0_b     = b;
            bus.req0_cin   = ci;
            bus.req0_valid = 1'b1;
        end
    endtask

    task automatic wait_accepts(input int n);
        int got = 0;
        for (int i = 0; i < 200 && got < n; i++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) got++;
        end
        if (got < n) begin
            compared++;
            mismatched++;
            $display("FAIL accept_timeout: got %0d accepts want %0d", got, n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.rsp_valid) done = 1'b1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req0_valid = 1'b0;
        bus.req0_oper  = '0;
        bus.req0_a     = '0;
        bus.req0_b     = '0;
        bus.req0_cin   = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req1_oper  = '0;
        bus.req1_a     = '0;
        bus.req1_b     = '0;
        bus.req1_cin   = 1'b0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Single carry chain through both passes.
        push_exp(1'b0, 16'h0100, 1'b0);
        set_req(1'b0, 3'b000, 16'h00FF, 16'h0001, 1'b0);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        drain();

        // Full-width overflow from requester 1.
        push_exp(1'b1, 16'h0000, 1'b1);
        set_req(1'b1, 3'b101, 16'hFFFF, 16'h0001, 1'b0);
        wait_accepts(1);
        bus.req1_valid = 1'b0;
        drain();

        // Continuous tie: grants alternate 0,1,0,1.
        push_exp(1'b0, 16'h1335, 1'b0);
        push_exp(1'b1, 16'h0001, 1'b1);
        push_exp(1'b0, 16'h1335, 1'b0);
        push_exp(1'b1, 16'h0001, 1'b1);
        set_req(1'b0, 3'b010, 16'h1234, 16'h0101, 1'b0);
        set_req(1'b1, 3'b011, 16'h8000, 16'h8000, 1'b1);
        wait_accepts(4);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        // Response backpressure with requester 1 waiting.
        bus.rsp_ready = 1'b0;
        push_exp(1'b0, 16'h3334, 1'b0);
        push_exp(1'b1, 16'h1000, 1'b0);
        set_req(1'b1, 3'b110, 16'h00F0, 16'h0F10, 1'b0);
        set_req(1'b0, 3'b001, 16'h1111, 16'h2222, 1'b1);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
        chk("bp_rsp_valid", bus.rsp_valid, 1);
        repeat (5) @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_accepts(1);
        bus.req1_valid = 1'b0;
        drain();

        // Reset during pass 1 aborts the operation.
        set_req(1'b0, 3'b100, 16'h0102, 16'h0304, 1'b0);
        wait_accepts(1);
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #2;
        set_req(1'b0, 3'b000, 16'h7F80, 16'h0080, 1'b0);
        set_req(1'b1, 3'b111, 16'hFFFE, 16'h0000, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_alu", {bus.alu_oper, bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
        chk("abort_ready", {bus.req1_ready, bus.req0_ready}, 0);
        push_exp(1'b0, 16'h8000, 1'b0);
        push_exp(1'b1, 16'hFFFF, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wait_accepts(2);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
